regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 5, register address width; depth is 2**ADDRESS_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 SHALL have parameter READ_PORTS, default 2, number of combinational read ports (1..4).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 A  input  READ_PORTS*ADDRESS_WIDTH  read addresses, port i at bits [i*ADDRESS_WIDTH +: ADDRESS_WIDTH].
REQ-007 RD  output  READ_PORTS*DATA_WIDTH  read data, port i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 Pend  output  READ_PORTS  scoreboard pending flag for each read address.
REQ-009 A3, WD3, WE3  input  ADDRESS_WIDTH, DATA_WIDTH, 1  write address, write data, write enable.
REQ-010 Issue, IssueAddr  input  1, ADDRESS_WIDTH  marks the destination register of an in-flight instruction as pending.
REQ-011 ClrReq  input  1  requests a full sequential clear of the register contents.
REQ-012 Ready  output  1  high when in IDLE; low while clearing.

Function
REQ-013 SHALL implement a two-state FSM {CLEAR, IDLE}, with a clear counter clr_cnt of ADDRESS_WIDTH bits.
REQ-014 In CLEAR, each edge SHALL write zero to reg[clr_cnt] and increment clr_cnt; when clr_cnt == 2**ADDRESS_WIDTH-1, SHALL write that register, enter IDLE and set Ready=1 on the same edge.
REQ-015 A full clear SHALL take exactly 2**ADDRESS_WIDTH-1 edges (31 at defaults); register 0 is never written.
REQ-016 In IDLE, ClrReq=1 SHALL load clr_cnt=1, clear all pending bits, enter CLEAR and drive Ready=0 from the next cycle.
REQ-017 ClrReq in CLEAR SHALL be ignored; the sweep continues without restarting.
REQ-018 In CLEAR, WE3 and Issue SHALL be ignored, and all RD and Pend bits SHALL read 0.
REQ-019 In IDLE, WE3=1 with A3!=0 SHALL write WD3 to reg[A3] at the edge; writes to A3=0 are discarded.
REQ-020 Reads SHALL be combinational, and address 0 SHALL always return 0.
REQ-021 The scoreboard SHALL hold one pending bit per register, and bit 0 SHALL be constantly 0.
REQ-022 In IDLE, Issue=1 SHALL set pend[IssueAddr]; WE3=1 SHALL clear pend[A3].
REQ-023 If Issue and WE3 target the same nonzero address in the same cycle, the set SHALL win (pending stays 1).
REQ-024 If Issue and WE3 target different addresses, both updates SHALL take effect on the same edge.
REQ-025 Pend[i] SHALL equal pend[A_i] from the registered scoreboard, not forwarded from the same-cycle Issue or WE3.
REQ-026 Re-issuing an address that is already pending SHALL leave it pending; there is no count, only a single bit.

Reset
REQ-027 While rst_n=0 at an edge, the block SHALL set state=CLEAR, clr_cnt=1, Ready=0 and all pending bits=0.
REQ-028 Register contents SHALL NOT be reset directly; they are zeroed by the CLEAR sweep once rst_n=1.
REQ-029 Reset asserted mid-sweep or mid-operation SHALL restart the sweep from register 1 on the first edge with rst_n=1.

Configuration
REQ-030 Macro REGFILE_BYPASS_EN defined: in IDLE, if WE3=1, A3!=0 and A_i==A3, RD port i SHALL return WD3 in the same cycle and Pend[i] SHALL read 0.
REQ-031 Macro REGFILE_BYPASS_EN undefined: RD SHALL return the stored value, which is the old value until the write edge, and Pend SHALL be per REQ-025.

Verification
REQ-032 Reset, then 31 edges with rst_n=1 -> Ready=0 through edge 30, Ready=1 after edge 31; every RD=0, Pend=0.
REQ-033 In IDLE, write A3=5, WD3=0xDEADBEEF, then read A0=5 and A1=0 -> RD0=0xDEADBEEF, RD1=0; a write to A3=0 leaves RD at 0.
REQ-034 Issue IssueAddr=7, then WE3 A3=7 two cycles later -> Pend=1 for 2 cycles, then 0; Issue and WE3 both to 7 in one cycle -> Pend stays 1.
REQ-035 Write 0x1234 to reg[9], pulse ClrReq, then apply WE3 to reg[9] during CLEAR -> write ignored; after 31 edges Ready=1 and reg[9]=0.
REQ-036 REGFILE_BYPASS_EN set, reg[3]=0x11, WE3 A3=3, WD3=0x22, A0=3 -> RD0=0x22 in the same cycle; with the macro unset -> RD0=0x11, then 0x22 after the edge.
REQ-037 Assert rst_n=0 at sweep edge 10, release -> Ready rises exactly 31 edges after the release.

Source files
------------

// File: rtl/regfile_sb.sv
// Register file with per-register scoreboard and a sequential clear sweep.
// Optional same-cycle write-to-read bypass when REGFILE_BYPASS_EN is defined.
//
// state | meaning
// ------+----------------------------------------------------------
// CLEAR | sweeping registers 1..DEPTH-1 to zero; writes/issues ignored
// IDLE  | normal operation; reads, writes and scoreboard updates active
module regfile_sb #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int READ_PORTS    = 2
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [READ_PORTS*ADDRESS_WIDTH-1:0] A,
   output logic [READ_PORTS*DATA_WIDTH-1:0]    RD,
   output logic [READ_PORTS-1:0]               Pend,
   input  logic [ADDRESS_WIDTH-1:0]            A3,
   input  logic [DATA_WIDTH-1:0]               WD3,
   input  logic                                WE3,
   input  logic                                Issue,
   input  logic [ADDRESS_WIDTH-1:0]            IssueAddr,
   input  logic                                ClrReq,
   output logic                                Ready
);

   localparam int DEPTH = 2**ADDRESS_WIDTH;
   localparam logic [ADDRESS_WIDTH-1:0] CNT_ONE  = ADDRESS_WIDTH'(1);
   localparam logic [ADDRESS_WIDTH-1:0] CNT_LAST = '1;

   typedef enum logic {CLEAR, IDLE} state_t;

   state_t                   state;
   logic [ADDRESS_WIDTH-1:0] clr_cnt;
   logic [DEPTH-1:0]         pend;
   logic [DEPTH-1:0]         pend_next;
   logic [DATA_WIDTH-1:0]    regs [DEPTH];

   // Set beats clear when Issue and WE3 hit the same register.
   always_comb begin
      pend_next = pend;
      if (WE3)
         pend_next[A3] = 1'b0;
      if (Issue)
         pend_next[IssueAddr] = 1'b1;
      pend_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= CLEAR;
         clr_cnt <= CNT_ONE;
         Ready   <= 1'b0;
         pend    <= '0;
      end else begin
         case (state)
            CLEAR: begin
               clr_cnt <= clr_cnt + CNT_ONE;
               if (clr_cnt == CNT_LAST) begin
                  state <= IDLE;
                  Ready <= 1'b1;
               end
            end
            IDLE: begin
               if (ClrReq) begin
                  clr_cnt <= CNT_ONE;
                  pend    <= '0;
                  state   <= CLEAR;
                  Ready   <= 1'b0;
               end else begin
                  pend <= pend_next;
               end
            end
         endcase
      end
   end

   // Storage has no reset; the sweep zeroes it once reset is released.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state == CLEAR)
            regs[clr_cnt] <= '0;
         else if (!ClrReq && WE3 && (A3 != '0))
            regs[A3] <= WD3;
      end
   end

   for (genvar i = 0; i < READ_PORTS; i++) begin : g_rd
      logic [ADDRESS_WIDTH-1:0] addr;
      logic                     hit;

      assign addr = A[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
`ifdef REGFILE_BYPASS_EN
      assign hit = (state == IDLE) && WE3 && (A3 != '0) && (addr == A3);
`else
      assign hit = 1'b0;
`endif
      assign RD[i*DATA_WIDTH +: DATA_WIDTH] =
         ((state != IDLE) || (addr == '0)) ? '0 :
         hit                               ? WD3 : regs[addr];
      assign Pend[i] = (state == IDLE) && !hit && pend[addr];
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic
// against a simple array/flag model of the register file and scoreboard.
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  a;
   logic [63:0] rd;
   logic [1:0]  pend;
   logic [4:0]  a3;
   logic [31:0] wd3;
   logic        we3;
   logic        issue;
   logic [4:0]  issue_addr;
   logic        clr_req;
   logic        ready;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model
   logic [31:0] m_mem [32];
   bit          m_pend [32];
   bit          m_clearing;
   int          m_swept;

   regfile_sb dut (
      .clk(clk), .rst_n(rst_n), .A(a), .RD(rd), .Pend(pend),
      .A3(a3), .WD3(wd3), .WE3(we3), .Issue(issue), .IssueAddr(issue_addr),
      .ClrReq(clr_req), .Ready(ready)
   );

   always #5 clk = ~clk;

   function automatic bit bypass_hit(int addr);
`ifdef REGFILE_BYPASS_EN
      return !m_clearing && we3 && (a3 != 0) && (int'(a3) == addr);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] exp_rd(int port);
      int addr;
      addr = int'(a[port*5 +: 5]);
      if (m_clearing || addr == 0) return 32'h0;
      if (bypass_hit(addr)) return wd3;
      return m_mem[addr];
   endfunction

   function automatic logic exp_pend(int port);
      int addr;
      addr = int'(a[port*5 +: 5]);
      if (m_clearing || addr == 0 || bypass_hit(addr)) return 1'b0;
      return m_pend[addr];
   endfunction

   // Apply the behavioural rules for one rising edge using the current inputs.
   task automatic model_edge();
      if (!rst_n) begin
         m_clearing = 1;
         m_swept    = 0;
         foreach (m_pend[k]) m_pend[k] = 0;
      end else if (m_clearing) begin
         m_swept++;
         m_mem[m_swept] = 32'h0;
         if (m_swept == 31) m_clearing = 0;
      end else if (clr_req) begin
         m_clearing = 1;
         m_swept    = 0;
         foreach (m_pend[k]) m_pend[k] = 0;
      end else begin
         if (we3 && a3 != 0) m_mem[a3] = wd3;
         if (we3) m_pend[a3] = 0;
         if (issue && issue_addr != 0) m_pend[issue_addr] = 1;
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      we3 = 0; issue = 0; clr_req = 0; a3 = 0; wd3 = 0; issue_addr = 0;
   endtask

   task automatic test_reset();
      rst_n = 0; a = 10'd0; idle_inputs();
      repeat (3) tick();
      n_tests++;
      if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready actual=%b required=0", ready); end
      n_tests++;
      if (rd !== 64'h0 || pend !== 2'b00) begin n_fail++; $display("FAIL reset_outputs rd=%h pend=%b required 0", rd, pend); end
      rst_n = 1;
      for (int e = 1; e <= 31; e++) begin
         tick();
         n_tests++;
         if (ready !== (e == 31)) begin n_fail++; $display("FAIL sweep_ready edge=%0d actual=%b required=%b", e, ready, (e == 31)); end
      end
      a = {5'd31, 5'd1};
      #1;
      n_tests++;
      if (rd !== 64'h0 || pend !== 2'b00) begin n_fail++; $display("FAIL post_sweep_zero rd=%h pend=%b required 0", rd, pend); end
   endtask

   task automatic test_write_read();
      we3 = 1; a3 = 5'd5; wd3 = 32'hDEADBEEF;
      tick();
      idle_inputs();
      a = {5'd0, 5'd5};
      #1;
      n_tests++;
      if (rd[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_port0 actual=%h required=deadbeef", rd[31:0]); end
      n_tests++;
      if (rd[63:32] !== 32'h0) begin n_fail++; $display("FAIL read_addr0 actual=%h required=0", rd[63:32]); end
      we3 = 1; a3 = 5'd0; wd3 = 32'hFFFFFFFF;
      tick();
      idle_inputs();
      a = {5'd0, 5'd0};
      #1;
      n_tests++;
      if (rd !== 64'h0) begin n_fail++; $display("FAIL write_addr0 actual=%h required=0", rd); end
   endtask

   task automatic test_pend();
      a = {5'd7, 5'd7};
      issue = 1; issue_addr = 5'd7;
      tick();
      idle_inputs();
      #1;
      n_tests++;
      if (pend[0] !== 1'b1) begin n_fail++; $display("FAIL pend_after_issue actual=%b required=1", pend[0]); end
      tick();
      we3 = 1; a3 = 5'd7; wd3 = 32'h77;
      #1;
      n_tests++;
`ifdef REGFILE_BYPASS_EN
      if (pend[0] !== 1'b0) begin n_fail++; $display("FAIL pend_bypass actual=%b required=0", pend[0]); end
`else
      if (pend[0] !== 1'b1) begin n_fail++; $display("FAIL pend_not_forwarded actual=%b required=1", pend[0]); end
`endif
      tick();
      idle_inputs();
      #1;
      n_tests++;
      if (pend[0] !== 1'b0) begin n_fail++; $display("FAIL pend_cleared actual=%b required=0", pend[0]); end
      issue = 1; issue_addr = 5'd7; we3 = 1; a3 = 5'd7; wd3 = 32'h78;
      tick();
      idle_inputs();
      #1;
      n_tests++;
      if (pend[0] !== 1'b1) begin n_fail++; $display("FAIL set_wins actual=%b required=1", pend[0]); end
      a = {5'd8, 5'd7};
      issue = 1; issue_addr = 5'd8; we3 = 1; a3 = 5'd7; wd3 = 32'h79;
      tick();
      idle_inputs();
      #1;
      n_tests++;
      if (pend !== 2'b10) begin n_fail++; $display("FAIL both_updates actual=%b required=10", pend); end
      issue = 1; issue_addr = 5'd8;
      tick();
      idle_inputs();
      #1;
      n_tests++;
      if (pend !== 2'b10) begin n_fail++; $display("FAIL reissue actual=%b required=10", pend); end
   endtask

   task automatic test_bypass();
      we3 = 1; a3 = 5'd3; wd3 = 32'h11;
      tick();
      a = {5'd0, 5'd3};
      wd3 = 32'h22;
      #1;
      n_tests++;
`ifdef REGFILE_BYPASS_EN
      if (rd[31:0] !== 32'h22) begin n_fail++; $display("FAIL bypass_same_cycle actual=%h required=22", rd[31:0]); end
`else
      if (rd[31:0] !== 32'h11) begin n_fail++; $display("FAIL old_value_before_edge actual=%h required=11", rd[31:0]); end
`endif
      tick();
      idle_inputs();
      #1;
      n_tests++;
      if (rd[31:0] !== 32'h22) begin n_fail++; $display("FAIL value_after_edge actual=%h required=22", rd[31:0]); end
   endtask

   task automatic test_clear_req();
      we3 = 1; a3 = 5'd9; wd3 = 32'h1234;
      issue = 1; issue_addr = 5'd9;
      tick();
      idle_inputs();
      clr_req = 1;
      tick();
      clr_req = 0;
      n_tests++;
      if (ready !== 1'b0) begin n_fail++; $display("FAIL clr_ready_low actual=%b required=0", ready); end
      we3 = 1; a3 = 5'd9; wd3 = 32'hABCD; issue = 1; issue_addr = 5'd9;
      a = {5'd9, 5'd9};
      for (int e = 1; e <= 31; e++) begin
         clr_req = (e == 15);
         tick();
         n_tests++;
         if (ready !== (e == 31)) begin n_fail++; $display("FAIL clr_sweep_ready edge=%0d actual=%b required=%b", e, ready, (e == 31)); end
      end
      idle_inputs();
      #1;
      n_tests++;
      if (rd !== 64'h0 || pend !== 2'b00) begin n_fail++; $display("FAIL clr_write_ignored rd=%h pend=%b required 0", rd, pend); end
   endtask

   task automatic test_reset_mid_sweep();
      clr_req = 1;
      tick();
      clr_req = 0;
      repeat (9) tick();
      rst_n = 0;
      tick();
      rst_n = 1;
      for (int e = 1; e <= 31; e++) begin
         tick();
         n_tests++;
         if (ready !== (e == 31)) begin n_fail++; $display("FAIL restart_ready edge=%0d actual=%b required=%b", e, ready, (e == 31)); end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 1500; c++) begin
         rst_n      = ($urandom_range(0, 299) != 0);
         clr_req    = ($urandom_range(0, 59) == 0);
         we3        = $urandom_range(0, 1);
         issue      = ($urandom_range(0, 2) == 0);
         a3         = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
         issue_addr = 5'($urandom_range(0, 7));
         wd3        = $urandom;
         a          = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 1) ? a3 : $urandom_range(0, 31))};
         #1;
         for (int p = 0; p < 2; p++) begin
            n_tests++;
            if (rd[p*32 +: 32] !== exp_rd(p)) begin n_fail++; $display("FAIL rand_rd cyc=%0d port=%0d actual=%h required=%h", c, p, rd[p*32 +: 32], exp_rd(p)); end
            n_tests++;
            if (pend[p] !== exp_pend(p)) begin n_fail++; $display("FAIL rand_pend cyc=%0d port=%0d actual=%b required=%b", c, p, pend[p], exp_pend(p)); end
         end
         n_tests++;
         if (ready !== !m_clearing) begin n_fail++; $display("FAIL rand_ready cyc=%0d actual=%b required=%b", c, ready, !m_clearing); end
         tick();
      end
      rst_n = 1;
      idle_inputs();
   endtask

   initial begin
      foreach (m_mem[k]) m_mem[k] = 32'h0;
      foreach (m_pend[k]) m_pend[k] = 0;
      m_clearing = 1;
      m_swept    = 0;
      test_reset();
      test_write_read();
      test_pend();
      test_bypass();
      test_clear_req();
      test_reset_mid_sweep();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
